// File: rtl/PARAMS_pkg.sv
// Shared sizes, funct3 access codes and the memory-stage state type.
package PARAMS_pkg;

    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_SIZE = 5;
    localparam int FUNCT3_SIZE    = 3;
    localparam int BE_SIZE        = WD_SIZE / 8;

    localparam logic [FUNCT3_SIZE-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_SIZE-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_SIZE-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_SIZE-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_SIZE-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational access checker, store lane steering and load extraction.
module mem_align
    import PARAMS_pkg::*;
(
    input  logic                   is_ld,
    input  logic                   is_st,
    input  logic [1:0]             off,
    input  logic [FUNCT3_SIZE-1:0] funct3,
    input  logic [WD_SIZE-1:0]     rs2_data,
    input  logic [WD_SIZE-1:0]     ld_q,
    output logic                   access_ok,
    output logic                   access_err,
    output logic [BE_SIZE-1:0]     be,
    output logic [WD_SIZE-1:0]     wdata,
    output logic [WD_SIZE-1:0]     ld_ext
);

    logic               width_ok;
    logic               misaligned;
    logic               mem_op;
    logic [WD_SIZE-1:0] shifted;

    always_comb begin
        width_ok   = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:  width_ok = 1'b1;
            F3_H: begin
                width_ok   = 1'b1;
                misaligned = off[0];
            end
            F3_W: begin
                width_ok   = 1'b1;
                misaligned = (off != 2'b00);
            end
            // unsigned codes only exist for loads
            F3_BU: width_ok = is_ld;
            F3_HU: begin
                width_ok   = is_ld;
                misaligned = off[0];
            end
            default: width_ok = 1'b0;
        endcase
        mem_op     = is_ld | is_st;
        access_ok  = mem_op & width_ok & ~misaligned;
        access_err = mem_op & ~(width_ok & ~misaligned);
    end

    always_comb begin
        be    = '1;
        wdata = rs2_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_SIZE'(1) << off;
                wdata = {BE_SIZE{rs2_data[7:0]}};
            end
            2'b01: begin
                be    = BE_SIZE'(3) << {off[1], 1'b0};
                wdata = {(BE_SIZE/2){rs2_data[15:0]}};
            end
            default: begin
                be    = '1;
                wdata = rs2_data;
            end
        endcase
    end

    always_comb begin
        shifted = ld_q >> {off, 3'b000};
        case (funct3)
            F3_B:    ld_ext = {{(WD_SIZE-8){shifted[7]}}, shifted[7:0]};
            F3_H:    ld_ext = {{(WD_SIZE-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_ext = {{(WD_SIZE-8){1'b0}}, shifted[7:0]};
            F3_HU:   ld_ext = {{(WD_SIZE-16){1'b0}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: request FSM, registered memory port and
// registered write-back bundle.
module stage_mem
    import PARAMS_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WD_SIZE-1:0]        alu_result_i,
    input  logic [WD_SIZE-1:0]        rs2_data_i,
    input  logic [INSTR_REG_SIZE-1:0] rd_i,
    input  logic                      ctrl_ld_i,
    input  logic                      ctrl_st_i,
    input  logic                      ctrl_reg_write_i,
    input  logic [FUNCT3_SIZE-1:0]    ctrl_mem_width_i,
    output logic                      stall_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [WD_SIZE-1:0]        mem_addr_o,
    output logic [BE_SIZE-1:0]        mem_be_o,
    output logic [WD_SIZE-1:0]        mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [WD_SIZE-1:0]        mem_rdata_i,
    output logic [WD_SIZE-1:0]        wb_data_o,
    output logic [INSTR_REG_SIZE-1:0] rd_o,
    output logic                      ctrl_reg_write_o,
    output logic                      mem_err_o
);

    mem_state_t         state_q;
    logic [WD_SIZE-1:0] ld_q;
    logic               is_st;
    logic               access_ok;
    logic               access_err;
    logic               idle;
    logic [BE_SIZE-1:0] be;
    logic [WD_SIZE-1:0] wdata;
    logic [WD_SIZE-1:0] ld_ext;

    // a simultaneous load and store is treated as a load
    assign is_st = ctrl_st_i & ~ctrl_ld_i;
    assign idle  = (state_q == MEM_IDLE);

    mem_align u_mem_align (
        .is_ld      (ctrl_ld_i),
        .is_st      (is_st),
        .off        (alu_result_i[1:0]),
        .funct3     (ctrl_mem_width_i),
        .rs2_data   (rs2_data_i),
        .ld_q       (ld_q),
        .access_ok  (access_ok),
        .access_err (access_err),
        .be         (be),
        .wdata      (wdata),
        .ld_ext     (ld_ext)
    );

    assign stall_o = (idle & access_ok) | (state_q == MEM_REQ) | (state_q == MEM_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MEM_IDLE;
            ld_q        <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (access_ok) begin
                        state_q     <= MEM_REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_st;
                        mem_addr_o  <= {alu_result_i[WD_SIZE-1:2], 2'b00};
                        mem_be_o    <= be;
                        mem_wdata_o <= wdata;
                    end
                end
                MEM_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= mem_we_o ? MEM_DONE : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        ld_q    <= mem_rdata_i;
                        state_q <= MEM_DONE;
                    end
                end
                // EX still holds the completed instruction, so no re-sample here
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_data_o        <= '0;
            rd_o             <= '0;
            ctrl_reg_write_o <= 1'b0;
            mem_err_o        <= 1'b0;
        end else begin
            mem_err_o <= idle & access_err;
            if (stall_o) begin
                ctrl_reg_write_o <= 1'b0;
            end else begin
                rd_o             <= rd_i;
                ctrl_reg_write_o <= ctrl_reg_write_i & ~(idle & access_err);
                wb_data_o        <= ctrl_ld_i ? ld_ext : alu_result_i;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with hand-computed expectations.
module tb_stage_mem;
    import PARAMS_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        ctrl_ld_i = 1'b0;
    logic        ctrl_st_i = 1'b0;
    logic        ctrl_reg_write_i = 1'b0;
    logic [2:0]  ctrl_mem_width_i = '0;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        ctrl_reg_write_o;
    logic        mem_err_o;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned stall_cnt = 0;
    int unsigned gnt_cnt = 0;

    stage_mem dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_result_i     (alu_result_i),
        .rs2_data_i       (rs2_data_i),
        .rd_i             (rd_i),
        .ctrl_ld_i        (ctrl_ld_i),
        .ctrl_st_i        (ctrl_st_i),
        .ctrl_reg_write_i (ctrl_reg_write_i),
        .ctrl_mem_width_i (ctrl_mem_width_i),
        .stall_o          (stall_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_be_o         (mem_be_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .wb_data_o        (wb_data_o),
        .rd_o             (rd_o),
        .ctrl_reg_write_o (ctrl_reg_write_o),
        .mem_err_o        (mem_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Counts stall cycles and grants at each edge, then settles past the edge.
    task automatic tick();
        if (stall_o) stall_cnt++;
        if (mem_req_o && mem_gnt_i) gnt_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        ctrl_ld_i        = ld;
        ctrl_st_i        = st;
        ctrl_reg_write_i = rw;
        ctrl_mem_width_i = f3;
        alu_result_i     = alu;
        rs2_data_i       = rs2;
        rd_i             = rd;
    endtask

    task automatic nop();
        present(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    // Load with immediate grant and rvalid one cycle later; returns in the WB cycle.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic [31:0] exp_addr);
        present(1'b1, 1'b0, 1'b1, f3, addr, 32'h0, rd);
        stall_cnt = 0;
        #1;
        chk1("ld_idle_stall", stall_o, 1'b1);
        tick();
        chk1("ld_req", mem_req_o, 1'b1);
        chk32("ld_addr", mem_addr_o, exp_addr);
        chk1("ld_we", mem_we_o, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk1("ld_req_drop", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        tick();
        mem_rvalid_i = 1'b0;
        chk1("ld_done_stall", stall_o, 1'b0);
        chk1("ld_bubble", ctrl_reg_write_o, 1'b0);
        tick();
        chk32("ld_stall_cycles", stall_cnt, 32'd3);
    endtask

    initial begin
        // reset state
        #2;
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_we", mem_we_o, 1'b0);
        chk32("rst_addr", mem_addr_o, 32'h0);
        chk32("rst_be", {28'h0, mem_be_o}, 32'h0);
        chk32("rst_wb", wb_data_o, 32'h0);
        chk1("rst_rw", ctrl_reg_write_o, 1'b0);
        chk1("rst_err", mem_err_o, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;

        // ALU pass-through
        present(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'h0, 5'd5);
        #1;
        chk1("alu_stall", stall_o, 1'b0);
        tick();
        chk32("alu_wb", wb_data_o, 32'h1234);
        chk32("alu_rd", {27'h0, rd_o}, 32'd5);
        chk1("alu_rw", ctrl_reg_write_o, 1'b1);
        chk1("alu_req", mem_req_o, 1'b0);
        nop();

        // LB / LBU from 0x103, byte 3 of 0x80FF_0000
        run_load(32'h103, F3_B, 32'h80FF_0000, 5'd7, 32'h100);
        chk32("lb_wb", wb_data_o, 32'hFFFF_FF80);
        chk32("lb_rd", {27'h0, rd_o}, 32'd7);
        chk1("lb_rw", ctrl_reg_write_o, 1'b1);
        nop();
        tick();
        run_load(32'h103, F3_BU, 32'h80FF_0000, 5'd8, 32'h100);
        chk32("lbu_wb", wb_data_o, 32'h0000_0080);
        nop();
        tick();

        // SH upper half with two grant-delay cycles
        present(1'b0, 1'b1, 1'b0, F3_H, 32'h202, 32'hABCD_1234, 5'd0);
        stall_cnt = 0;
        #1;
        chk1("sh_idle_stall", stall_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("sh_req", mem_req_o, 1'b1);
            chk1("sh_we", mem_we_o, 1'b1);
            chk32("sh_addr", mem_addr_o, 32'h200);
            chk32("sh_be", {28'h0, mem_be_o}, 32'hC);
            chk32("sh_wdata", mem_wdata_o, 32'h1234_1234);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk1("sh_req_drop", mem_req_o, 1'b0);
        chk1("sh_done_stall", stall_o, 1'b0);
        tick();
        chk32("sh_stall_cycles", stall_cnt, 32'd4);
        chk1("sh_rw", ctrl_reg_write_o, 1'b0);
        nop();

        // misaligned LW, illegal load funct3, unsigned code on a store
        present(1'b1, 1'b0, 1'b1, F3_W, 32'h101, 32'h0, 5'd9);
        #1;
        chk1("mis_stall", stall_o, 1'b0);
        tick();
        chk1("mis_err", mem_err_o, 1'b1);
        chk1("mis_rw", ctrl_reg_write_o, 1'b0);
        chk1("mis_req", mem_req_o, 1'b0);
        present(1'b1, 1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 5'd9);
        tick();
        chk1("f3_011_err", mem_err_o, 1'b1);
        chk1("f3_011_rw", ctrl_reg_write_o, 1'b0);
        chk1("f3_011_req", mem_req_o, 1'b0);
        present(1'b0, 1'b1, 1'b0, F3_BU, 32'h100, 32'h55, 5'd0);
        tick();
        chk1("sbu_err", mem_err_o, 1'b1);
        chk1("sbu_req", mem_req_o, 1'b0);
        nop();
        tick();
        chk1("err_pulse_end", mem_err_o, 1'b0);

        // reset while waiting for rvalid
        present(1'b1, 1'b0, 1'b1, F3_W, 32'h300, 32'h0, 5'd2);
        #1;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        reset_n = 1'b0;
        nop();
        #1;
        chk1("rw_rst_req", mem_req_o, 1'b0);
        chk1("rw_rst_stall", stall_o, 1'b0);
        chk32("rw_rst_addr", mem_addr_o, 32'h0);
        chk32("rw_rst_wb", wb_data_o, 32'h0);
        tick();
        reset_n = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        tick();
        mem_rvalid_i = 1'b0;
        chk1("late_rv_stall", stall_o, 1'b0);
        chk1("late_rv_req", mem_req_o, 1'b0);
        chk32("late_rv_wb", wb_data_o, 32'h0);
        chk1("late_rv_rw", ctrl_reg_write_o, 1'b0);
        present(1'b0, 1'b0, 1'b1, 3'b000, 32'h77, 32'h0, 5'd6);
        tick();
        chk32("post_rst_alu_wb", wb_data_o, 32'h77);
        chk1("post_rst_alu_rw", ctrl_reg_write_o, 1'b1);
        nop();
        tick();

        // back-to-back LW then ALU op
        gnt_cnt = 0;
        run_load(32'h400, F3_W, 32'hDEAD_BEEF, 5'd3, 32'h400);
        chk32("lw_wb", wb_data_o, 32'hDEAD_BEEF);
        chk32("lw_rd", {27'h0, rd_o}, 32'd3);
        chk1("lw_rw", ctrl_reg_write_o, 1'b1);
        present(1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd4);
        tick();
        chk32("b2b_alu_wb", wb_data_o, 32'h55);
        chk32("b2b_alu_rd", {27'h0, rd_o}, 32'd4);
        chk1("b2b_alu_rw", ctrl_reg_write_o, 1'b1);
        chk1("b2b_no_req", mem_req_o, 1'b0);
        nop();
        tick();
        chk32("b2b_grants", gnt_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
